// File: rtl/pe_window_feeder_pkg.sv
// Shared types and geometry helpers for the PE window feeder.
// ZERO_PAD_EN selects same-size (zero padded) convolution instead of valid-only.
package pe_window_feeder_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_DRAIN = 2'd2
  } state_t;

`ifdef ZERO_PAD_EN
  localparam int PAD_EN = 1;
`else
  localparam int PAD_EN = 0;
`endif

  function automatic int pad_of(input int k);
    return PAD_EN * ((k - 1) / 2);
  endfunction

  function automatic int out_dim(input int img, input int k, input int pad);
    return img - k + 1 + 2 * pad;
  endfunction

endpackage

// File: rtl/pe_window_feeder_if.sv
// Control, SRAM read and PE operand bundle of the window feeder (ZERO_PAD_EN-agnostic).
// The master side is the feeder itself; the slave side is the SRAMs, PE and controller.
interface pe_window_feeder_if #(
  parameter int DW  = 16,
  parameter int PAW = 10,
  parameter int WAW = 5
);
  logic                  start;
  logic                  busy;
  logic                  done;
  logic                  pic_rd_en;
  logic [PAW-1:0]        pic_addr;
  logic signed [DW-1:0]  pic_rdata;
  logic                  wt_rd_en;
  logic [WAW-1:0]        wt_addr;
  logic signed [DW-1:0]  wt_rdata;
  logic signed [DW-1:0]  pe_pic;
  logic signed [DW-1:0]  pe_wt;
  logic                  pe_vld;
  logic                  pe_first;
  logic                  pe_last;

  modport master (
    input  start, pic_rdata, wt_rdata,
    output busy, done, pic_rd_en, pic_addr, wt_rd_en, wt_addr,
           pe_pic, pe_wt, pe_vld, pe_first, pe_last
  );

  modport slave (
    output start, pic_rdata, wt_rdata,
    input  busy, done, pic_rd_en, pic_addr, wt_rd_en, wt_addr,
           pe_pic, pe_wt, pe_vld, pe_first, pe_last
  );
endinterface

// File: rtl/pe_window_feeder_window_addr_gen.sv
// kx/ky/ox/oy counter nest with incremental (multiplier-free) pixel/weight addressing.
// With ZERO_PAD_EN the window origin is shifted by -PAD and off-map taps raise oob.
module window_addr_gen
  import pe_window_feeder_pkg::*;
#(
  parameter int K     = 5,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PAW   = 10,
  parameter int WAW   = 5
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           clear,
  input  logic           adv,
  output logic [PAW-1:0] pic_addr,
  output logic [WAW-1:0] wt_addr,
  output logic           oob,
  output logic           first,
  output logic           last,
  output logic           final_tap
);
  localparam int PAD = pad_of(K);
  localparam int OW  = out_dim(IMG_W, K, PAD);
  localparam int OH  = out_dim(IMG_H, K, PAD);
  localparam int KK  = K * K;
  localparam int CW  = $clog2(IMG_W + IMG_H + 2 * K) + 1;
  localparam int LW  = (PAD_EN != 0) ? PAW + 3 : PAW;

  localparam logic [CW-1:0]        K_LAST   = CW'(K - 1);
  localparam logic [CW-1:0]        OW_LAST  = CW'(OW - 1);
  localparam logic [CW-1:0]        OH_LAST  = CW'(OH - 1);
  localparam logic [CW-1:0]        C_ONE    = CW'(1);
  localparam logic [WAW-1:0]       WT_LAST  = WAW'(KK - 1);
  localparam logic [WAW-1:0]       WT_ONE   = WAW'(1);
  localparam logic signed [LW-1:0] ORIGIN   = LW'(-(PAD * IMG_W + PAD));
  localparam logic signed [LW-1:0] ROW_STEP = LW'(IMG_W);
  localparam logic signed [LW-1:0] L_ONE    = LW'(1);

  logic [CW-1:0]        kx, ky, ox, oy;
  logic [WAW-1:0]       wt_cnt;
  // lin tracks the current tap; the bases are its value at the start of the
  // current tap row, the current window, and the current output row.
  logic signed [LW-1:0] lin, row_base, win_base, oy_base;
  logic signed [LW-1:0] row_nxt, win_nxt, oyb_nxt;

  assign row_nxt = row_base + ROW_STEP;
  assign win_nxt = win_base + L_ONE;
  assign oyb_nxt = oy_base + ROW_STEP;

  always_ff @(posedge clk) begin
    if (rst || clear) begin
      kx       <= '0;
      ky       <= '0;
      ox       <= '0;
      oy       <= '0;
      wt_cnt   <= '0;
      lin      <= ORIGIN;
      row_base <= ORIGIN;
      win_base <= ORIGIN;
      oy_base  <= ORIGIN;
    end else if (adv) begin
      wt_cnt <= (wt_cnt == WT_LAST) ? '0 : wt_cnt + WT_ONE;
      if (kx != K_LAST) begin
        kx  <= kx + C_ONE;
        lin <= lin + L_ONE;
      end else begin
        kx <= '0;
        if (ky != K_LAST) begin
          ky       <= ky + C_ONE;
          row_base <= row_nxt;
          lin      <= row_nxt;
        end else begin
          ky <= '0;
          if (ox != OW_LAST) begin
            ox       <= ox + C_ONE;
            win_base <= win_nxt;
            row_base <= win_nxt;
            lin      <= win_nxt;
          end else begin
            ox <= '0;
            if (oy != OH_LAST) begin
              oy       <= oy + C_ONE;
              oy_base  <= oyb_nxt;
              win_base <= oyb_nxt;
              row_base <= oyb_nxt;
              lin      <= oyb_nxt;
            end else begin
              oy       <= '0;
              oy_base  <= ORIGIN;
              win_base <= ORIGIN;
              row_base <= ORIGIN;
              lin      <= ORIGIN;
            end
          end
        end
      end
    end
  end

`ifdef ZERO_PAD_EN
  localparam logic [CW-1:0] PAD_C = CW'(PAD);
  localparam logic [CW-1:0] R_END = CW'(IMG_H + PAD);
  localparam logic [CW-1:0] C_END = CW'(IMG_W + PAD);

  logic [CW-1:0]  r_sum, c_sum;
  logic [PAW-1:0] held_addr;

  assign r_sum = oy + ky;
  assign c_sum = ox + kx;
  assign oob   = (r_sum < PAD_C) || (r_sum >= R_END) || (c_sum < PAD_C) || (c_sum >= C_END);

  // Padded taps issue no pixel read, so the address bus keeps its last real value.
  always_ff @(posedge clk) begin
    if (rst)
      held_addr <= '0;
    else if (adv && !oob)
      held_addr <= lin[PAW-1:0];
  end

  assign pic_addr = oob ? held_addr : lin[PAW-1:0];
`else
  assign oob      = 1'b0;
  assign pic_addr = lin[PAW-1:0];
`endif

  assign wt_addr   = wt_cnt;
  assign first     = (wt_cnt == '0);
  assign last      = (wt_cnt == WT_LAST);
  assign final_tap = last && (ox == OW_LAST) && (oy == OH_LAST);

endmodule

// File: rtl/pe_window_feeder.sv
// Streams K*K (pixel, weight) pairs per conv window into the PE through a 2-stage pipe.
// Build with ZERO_PAD_EN for zero-padded same-size convolution.
module pe_window_feeder
  import pe_window_feeder_pkg::*;
#(
  parameter int K     = 5,
  parameter int DW    = 16,
  parameter int IMG_W = 28,
  parameter int IMG_H = 28,
  parameter int PAW   = 10,
  parameter int WAW   = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  pe_window_feeder_if.master   bus
);
  state_t state, state_nxt;
  logic   drain_cnt;
  logic   issue, clear;
  logic   oob, first_tap, last_tap, final_tap;

  logic   vld_p0, first_p0, last_p0, final_p0, oob_p0;
  logic   vld_p1, first_p1, last_p1, done_p1;
  logic signed [DW-1:0] pic_p1, wt_p1;

  window_addr_gen #(
    .K     (K),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H),
    .PAW   (PAW),
    .WAW   (WAW)
  ) u_addr (
    .clk       (clk),
    .rst       (rst),
    .clear     (clear),
    .adv       (issue),
    .pic_addr  (bus.pic_addr),
    .wt_addr   (bus.wt_addr),
    .oob       (oob),
    .first     (first_tap),
    .last      (last_tap),
    .final_tap (final_tap)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ST_IDLE;
      drain_cnt <= 1'b0;
    end else begin
      state     <= state_nxt;
      drain_cnt <= (state == ST_DRAIN) && !drain_cnt;
    end
  end

  always_comb begin
    state_nxt = state;
    issue     = 1'b0;
    clear     = 1'b0;
    unique case (state)
      ST_IDLE: begin
        if (bus.start) begin
          state_nxt = ST_RUN;
          clear     = 1'b1;
        end
      end
      ST_RUN: begin
        issue = 1'b1;
        if (final_tap) state_nxt = ST_DRAIN;
      end
      ST_DRAIN: begin
        if (drain_cnt) state_nxt = ST_IDLE;
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  assign bus.busy      = (state != ST_IDLE);
  assign bus.pic_rd_en = issue && !oob;
  assign bus.wt_rd_en  = issue;

  // p0: sideband aligned with the SRAM read data
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p0   <= 1'b0;
      first_p0 <= 1'b0;
      last_p0  <= 1'b0;
      final_p0 <= 1'b0;
      oob_p0   <= 1'b0;
    end else begin
      vld_p0   <= issue;
      first_p0 <= first_tap;
      last_p0  <= last_tap;
      final_p0 <= final_tap;
      oob_p0   <= oob;
    end
  end

  // p1: registered PE operands and framing
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_p1   <= 1'b0;
      first_p1 <= 1'b0;
      last_p1  <= 1'b0;
      done_p1  <= 1'b0;
    end else begin
      vld_p1   <= vld_p0;
      first_p1 <= vld_p0 && first_p0;
      last_p1  <= vld_p0 && last_p0;
      done_p1  <= vld_p0 && final_p0;
    end
  end

  always_ff @(posedge clk) begin
    pic_p1 <= oob_p0 ? '0 : bus.pic_rdata;
    wt_p1  <= bus.wt_rdata;
  end

  assign bus.pe_vld   = vld_p1;
  assign bus.pe_pic   = vld_p1 ? pic_p1 : '0;
  assign bus.pe_wt    = vld_p1 ? wt_p1 : '0;
  assign bus.pe_first = first_p1;
  assign bus.pe_last  = last_p1;
  assign bus.done     = done_p1;

endmodule

// File: tb/tb_pe_window_feeder.sv
// Scoreboard bench for pe_window_feeder (K=3, 4x4 map); honours ZERO_PAD_EN.
module tb_pe_window_feeder;
  localparam int K     = 3;
  localparam int DW    = 16;
  localparam int IMG_W = 4;
  localparam int IMG_H = 4;
  localparam int PAW   = 4;
  localparam int WAW   = 4;
`ifdef ZERO_PAD_EN
  localparam int PAD = 1;
`else
  localparam int PAD = 0;
`endif
  localparam int OW = IMG_W - K + 1 + 2 * PAD;
  localparam int OH = IMG_H - K + 1 + 2 * PAD;

  typedef struct {
    logic signed [DW-1:0] pic;
    logic signed [DW-1:0] wt;
    logic                 first;
    logic                 last;
    logic                 done;
  } pair_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  pe_window_feeder_if #(.DW(DW), .PAW(PAW), .WAW(WAW)) bus ();

  pe_window_feeder #(
    .K(K), .DW(DW), .IMG_W(IMG_W), .IMG_H(IMG_H), .PAW(PAW), .WAW(WAW)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic signed [DW-1:0] pix_mem [0:2**PAW-1];
  logic signed [DW-1:0] wt_mem  [0:2**WAW-1];

  always @(posedge clk) begin
    if (bus.pic_rd_en) bus.pic_rdata <= pix_mem[bus.pic_addr];
    if (bus.wt_rd_en)  bus.wt_rdata  <= wt_mem[bus.wt_addr];
  end

  pair_t                q[$];
  logic signed [63:0]   sum_q[$];
  int                   rdq[$];
  int                   n_cmp  = 0;
  int                   n_fail = 0;
  bit                   armed  = 1'b0;
  int                   ncyc   = 0;
  int                   acc_cyc = -1;
  int                   rd_cnt = 0;
  int                   pair_idx = 0;
  int                   run_no = 0;
  bit                   wait_first = 1'b0;
  bit                   prev_done = 1'b0;
  bit                   chk_zero = 1'b0;
  logic signed [63:0]   acc = '0;
  logic signed [DW-1:0] win0 [0:8];
  int                   win0_exp [0:8];

  task automatic check(input string name, input logic signed [63:0] act,
                       input logic signed [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    n_cmp++;
    n_fail++;
    $display("FAIL %s (t=%0t)", name, $time);
  endtask

  // Closed-form model of one full run, pushed into the scoreboard queues.
  task automatic push_run();
    int r, c, inb;
    bit in_map;
    pair_t e;
    logic signed [63:0] s;
    inb = 0;
    for (int oy = 0; oy < OH; oy++) begin
      for (int ox = 0; ox < OW; ox++) begin
        s = '0;
        for (int ky = 0; ky < K; ky++) begin
          for (int kx = 0; kx < K; kx++) begin
            r = oy + ky - PAD;
            c = ox + kx - PAD;
            in_map  = (r >= 0) && (r < IMG_H) && (c >= 0) && (c < IMG_W);
            e.pic   = in_map ? pix_mem[r * IMG_W + c] : '0;
            e.wt    = wt_mem[ky * K + kx];
            e.first = (kx == 0) && (ky == 0);
            e.last  = (kx == K - 1) && (ky == K - 1);
            e.done  = e.last && (ox == OW - 1) && (oy == OH - 1);
            q.push_back(e);
            s = s + 64'(e.pic) * 64'(e.wt);
            if (in_map) inb++;
          end
        end
        sum_q.push_back(s);
      end
    end
    rdq.push_back(inb);
  endtask

  task automatic wait_done(input int max_cyc);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < max_cyc && !seen; i++) begin
      @(negedge clk);
      if (bus.done) seen = 1'b1;
    end
    if (!seen) fail_now("done_timeout");
  endtask

  task automatic run_plain();
    @(posedge clk);
    #1;
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(400);
    repeat (3) @(posedge clk);
  endtask

  // Monitor: pops the scoreboard on every pe_vld and checks timing and framing.
  initial begin
    pair_t e;
    forever begin
      @(negedge clk);
      ncyc++;
      if (!armed) continue;
      if (rst) begin
        q.delete();
        sum_q.delete();
        rdq.delete();
        chk_zero   = 1'b1;
        wait_first = 1'b0;
        prev_done  = 1'b0;
        continue;
      end
      if (chk_zero) begin
        chk_zero = 1'b0;
        check("abort_vld", bus.pe_vld, 0);
        check("abort_busy", bus.busy, 0);
        check("abort_outputs", {bus.pe_pic, bus.pe_wt, bus.pe_first, bus.pe_last,
                                bus.done, bus.pic_rd_en, bus.wt_rd_en}, 0);
      end
      if (prev_done) begin
        prev_done = 1'b0;
        check("busy_drop", bus.busy, 0);
      end
      if (bus.start && !bus.busy) begin
        acc_cyc    = ncyc;
        rd_cnt     = 0;
        wait_first = 1'b1;
        pair_idx   = 0;
        run_no++;
      end
      if (acc_cyc >= 0 && ncyc == acc_cyc + 1) begin
        check("rd_start_wt", bus.wt_rd_en, 1);
        check("rd_start_pic", bus.pic_rd_en, (PAD == 0) ? 1 : 0);
        check("busy_rise", bus.busy, 1);
      end
      if (bus.pic_rd_en) rd_cnt++;
      if (bus.pe_vld) begin
        if (wait_first) begin
          check("first_latency", ncyc - acc_cyc, 3);
          wait_first = 1'b0;
        end
        if (q.size() == 0) begin
          fail_now("unexpected_pair");
        end else begin
          e = q.pop_front();
          check("pair_pic", bus.pe_pic, e.pic);
          check("pair_wt", bus.pe_wt, e.wt);
          check("pair_tags", {bus.pe_first, bus.pe_last, bus.done},
                             {e.first, e.last, e.done});
        end
        if (run_no == 1 && pair_idx < 9) win0[pair_idx] = bus.pe_pic;
        pair_idx++;
        if (bus.pe_first) acc = '0;
        acc = acc + 64'(bus.pe_pic) * 64'(bus.pe_wt);
        if (bus.pe_last) begin
          if (sum_q.size() == 0) fail_now("unexpected_window");
          else check("window_sum", acc, sum_q.pop_front());
        end
        if (bus.done) begin
          if (rdq.size() == 0) fail_now("unexpected_done");
          else check("pic_rd_count", rd_cnt, rdq.pop_front());
          prev_done = 1'b1;
        end
      end else begin
        if (q.size() > 0 && !wait_first) fail_now("vld_gap");
        check("idle_zero", {bus.pe_pic, bus.pe_wt, bus.pe_first, bus.pe_last, bus.done}, 0);
      end
    end
  end

  initial begin
    int tmp;
`ifdef ZERO_PAD_EN
    win0_exp = '{0, 0, 0, 0, 0, 1, 0, 4, 5};
`else
    win0_exp = '{0, 1, 2, 4, 5, 6, 8, 9, 10};
`endif
    bus.start     = 1'b0;
    for (int i = 0; i < 2**PAW; i++) pix_mem[i] = DW'(i);
    for (int i = 0; i < 2**WAW; i++) wt_mem[i]  = DW'(i + 1);
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check("reset_busy", bus.busy, 0);
    check("reset_vld", bus.pe_vld, 0);
    check("reset_outputs", {bus.pe_pic, bus.pe_wt, bus.pe_first, bus.pe_last, bus.done,
                            bus.pic_rd_en, bus.wt_rd_en, bus.pic_addr, bus.wt_addr}, 0);
    armed = 1'b1;

    // Basic run and window-0 operand order
    run_plain();
    for (int i = 0; i < 9; i++) check("win0_pic", win0[i], win0_exp[i]);

    // start while busy (including the done cycle) is ignored; the cycle after done starts again
    @(posedge clk);
    #1;
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (4) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (10) @(posedge clk);
    #1 bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(400);
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1 bus.start = 1'b0;
    wait_done(400);
    repeat (3) @(posedge clk);

    // Reset during pair 12 aborts the run
    @(posedge clk);
    #1;
    push_run();
    bus.start = 1'b1;
    @(posedge clk);
    #1 bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    repeat (3) @(posedge clk);
    run_plain();

    // Signed random SRAM contents, checked window by window via the MAC sums
    for (int i = 0; i < 2**PAW; i++) begin
      tmp = int'($urandom_range(0, 2000)) - 1000;
      pix_mem[i] = DW'(tmp);
    end
    for (int i = 0; i < 2**WAW; i++) begin
      tmp = int'($urandom_range(0, 2000)) - 1000;
      wt_mem[i] = DW'(tmp);
    end
    run_plain();

    repeat (5) @(posedge clk);
    check("queue_drained", q.size(), 0);
    check("sums_drained", sum_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule
